// File: rtl/wm_pkg.sv
// Shared washing-machine definitions: phase and mode encodings plus the
// per-mode duration and price tables used by the controller and billing.
package wm_pkg;

   typedef enum logic [2:0] {
      PH_IDLE   = 3'd0,
      PH_CHARGE = 3'd1,
      PH_WASH   = 3'd2,
      PH_RINSE  = 3'd3,
      PH_SPIN   = 3'd4,
      PH_DONE   = 3'd5
   } phase_e;

   typedef enum logic [1:0] {
      MODE_DRY    = 2'b00,
      MODE_SMALL  = 2'b01,
      MODE_MEDIUM = 2'b10,
      MODE_LARGE  = 2'b11
   } mode_e;

   typedef struct packed {
      logic [5:0]  wash_s;
      logic [5:0]  rinse_s;
      logic [5:0]  spin_s;
      logic [11:0] price;
   } program_t;

   function automatic program_t program_of(input mode_e m);
      program_t p;
      case (m)
         MODE_DRY:    p = '{wash_s: 6'd0,  rinse_s: 6'd0,  spin_s: 6'd6, price: 12'd3};
         MODE_SMALL:  p = '{wash_s: 6'd10, rinse_s: 6'd6,  spin_s: 6'd4, price: 12'd5};
         MODE_MEDIUM: p = '{wash_s: 6'd15, rinse_s: 6'd8,  spin_s: 6'd6, price: 12'd8};
         MODE_LARGE:  p = '{wash_s: 6'd20, rinse_s: 6'd10, spin_s: 6'd8, price: 12'd12};
         default:     p = '0;
      endcase
      return p;
   endfunction

   function automatic logic [5:0] phase_dur(input mode_e m, input phase_e ph);
      program_t   p;
      logic [5:0] d;
      p = program_of(m);
      case (ph)
         PH_WASH:  d = p.wash_s;
         PH_RINSE: d = p.rinse_s;
         PH_SPIN:  d = p.spin_s;
         default:  d = 6'd0;
      endcase
      return d;
   endfunction

   // First phase after cur whose duration is non-zero; DONE when none remain.
   function automatic phase_e next_phase(input mode_e m, input phase_e cur);
      phase_e n;
      n = PH_DONE;
      if (cur < PH_SPIN  && phase_dur(m, PH_SPIN)  != 6'd0) n = PH_SPIN;
      if (cur < PH_RINSE && phase_dur(m, PH_RINSE) != 6'd0) n = PH_RINSE;
      if (cur < PH_WASH  && phase_dur(m, PH_WASH)  != 6'd0) n = PH_WASH;
      return n;
   endfunction

   function automatic logic [7:0] total_dur(input mode_e m);
      program_t p;
      p = program_of(m);
      return 8'(p.wash_s) + 8'(p.rinse_s) + 8'(p.spin_s);
   endfunction

endpackage

// File: rtl/sec_tick.sv
// One-second prescaler: pulses tick for one cycle after every CLK_HZ enabled
// cycles; clr restarts the count and en=0 freezes it in place.
module sec_tick #(
   parameter int CLK_HZ = 100_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int              CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_HZ - 1);

   logic [CNT_W-1:0] r_cnt;

   assign tick = en & (r_cnt == LAST);

   // NOTE: registers are written with <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= tick ? '0 : r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/wash_cycle_ctrl.sv
// Coin-op wash cycle controller: charges the selected program, then runs the
// non-empty WASH/RINSE/SPIN phases off a one-second tick with pause and abort.
module wash_cycle_ctrl
   import wm_pkg::*;
#(
   parameter int CLK_HZ = 100_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        on,
   input  logic        start,
   input  logic        pause,
   input  logic [1:0]  mode,
   input  logic        charge_ack,
   input  logic        charge_nak,
   output logic        charge_req,
   output logic [11:0] price,
   output logic [2:0]  phase,
   output logic [5:0]  phase_left,
   output logic [7:0]  total_left,
   output logic        busy,
   output logic        paused,
   output logic        done,
   output logic        err
);

   phase_e     r_state, w_state_nx;
   mode_e      r_mode, w_mode_nx;
   logic [5:0] r_phase_left, w_phase_left_nx;
   logic [7:0] r_total_left, w_total_left_nx;
   logic       r_err, w_err_nx;
   logic       r_start_d;

   logic       w_start_edge;
   logic       w_in_phase;
   logic       w_tick;
   logic       w_tick_clr;
   logic       w_tick_en;
   phase_e     w_first_ph;
   phase_e     w_next_ph;

   assign w_start_edge = start & ~r_start_d;
   assign w_in_phase   = (r_state == PH_WASH) || (r_state == PH_RINSE) || (r_state == PH_SPIN);
   assign w_first_ph   = next_phase(r_mode, PH_CHARGE);
   assign w_next_ph    = next_phase(r_mode, r_state);

   // Prescaler is held at zero outside the phases, so phase entry starts a fresh second.
   assign w_tick_clr = ~on | ~w_in_phase;
   assign w_tick_en  = w_in_phase & ~pause;

   sec_tick #(
      .CLK_HZ (CLK_HZ)
   ) u_sec_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (w_tick_clr),
      .en   (w_tick_en),
      .tick (w_tick)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= PH_IDLE;
         r_mode       <= MODE_DRY;
         r_phase_left <= '0;
         r_total_left <= '0;
         r_err        <= 1'b0;
         r_start_d    <= 1'b0;
      end else begin
         r_state      <= w_state_nx;
         r_mode       <= w_mode_nx;
         r_phase_left <= w_phase_left_nx;
         r_total_left <= w_total_left_nx;
         r_err        <= w_err_nx;
         r_start_d    <= start;
      end
   end

   // NOTE: every next-state variable takes its hold value first, so no path infers a latch.
   always_comb begin
      w_state_nx      = r_state;
      w_mode_nx       = r_mode;
      w_phase_left_nx = r_phase_left;
      w_total_left_nx = r_total_left;
      w_err_nx        = r_err;

      if (!on) begin
         w_state_nx      = PH_IDLE;
         w_phase_left_nx = '0;
         w_total_left_nx = '0;
      end else begin
         case (r_state)
            PH_IDLE: begin
               if (w_start_edge) begin
                  w_state_nx = PH_CHARGE;
                  w_mode_nx  = mode_e'(mode);
                  w_err_nx   = 1'b0;
               end
            end
            PH_CHARGE: begin
               if (charge_nak) begin
                  w_state_nx = PH_IDLE;
                  w_err_nx   = 1'b1;
               end else if (charge_ack) begin
                  w_state_nx      = w_first_ph;
                  w_phase_left_nx = phase_dur(r_mode, w_first_ph);
                  w_total_left_nx = total_dur(r_mode);
               end
            end
            PH_WASH, PH_RINSE, PH_SPIN: begin
               if (w_tick) begin
                  w_total_left_nx = r_total_left - 8'd1;
                  if (r_phase_left == 6'd1) begin
                     w_state_nx      = w_next_ph;
                     w_phase_left_nx = phase_dur(r_mode, w_next_ph);
                  end else begin
                     w_phase_left_nx = r_phase_left - 6'd1;
                  end
               end
            end
            PH_DONE: w_state_nx = PH_IDLE;
            default: w_state_nx = PH_IDLE;
         endcase
      end
   end

   assign charge_req = (r_state == PH_CHARGE);
   assign price      = charge_req ? program_of(r_mode).price : 12'd0;
   assign phase      = r_state;
   assign phase_left = r_phase_left;
   assign total_left = r_total_left;
   assign busy       = w_in_phase;
   assign paused     = w_in_phase & pause;
   assign done       = (r_state == PH_DONE);
   assign err        = r_err;

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Self-checking bench for wash_cycle_ctrl at CLK_HZ=4: a per-cycle trace of
// expected outputs is queued when a charge is accepted and popped as the DUT runs.
module tb_wash_cycle_ctrl;

   localparam int HZ = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        on;
   logic        start;
   logic        pause;
   logic [1:0]  mode;
   logic        charge_ack;
   logic        charge_nak;
   logic        charge_req;
   logic [11:0] price;
   logic [2:0]  phase;
   logic [5:0]  phase_left;
   logic [7:0]  total_left;
   logic        busy;
   logic        paused;
   logic        done;
   logic        err;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [2:0] ph;
      logic [5:0] pl;
      logic [7:0] tl;
      logic       bz;
      logic       pz;
      logic       dn;
   } obs_t;

   obs_t sb_q[$];

   always #5 clk = ~clk;

   wash_cycle_ctrl #(
      .CLK_HZ (HZ)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .on         (on),
      .start      (start),
      .pause      (pause),
      .mode       (mode),
      .charge_ack (charge_ack),
      .charge_nak (charge_nak),
      .charge_req (charge_req),
      .price      (price),
      .phase      (phase),
      .phase_left (phase_left),
      .total_left (total_left),
      .busy       (busy),
      .paused     (paused),
      .done       (done),
      .err        (err)
   );

   function automatic logic [11:0] price_of(input logic [1:0] m);
      case (m)
         2'b00:   return 12'd3;
         2'b01:   return 12'd5;
         2'b10:   return 12'd8;
         default: return 12'd12;
      endcase
   endfunction

   // Expected outputs after eff unpaused cycles since phase entry, derived from
   // the remaining total: the phase is whichever one the remaining seconds fall in.
   function automatic obs_t model(input int w, input int r, input int s, input int eff, input bit pz);
      obs_t o;
      int   tot;
      int   rem;
      o   = '0;
      tot = w + r + s;
      if (eff > HZ * tot) return o;
      rem = tot - eff / HZ;
      if (rem == 0) begin
         o.ph = 3'd5;
         o.dn = 1'b1;
         return o;
      end
      o.tl = 8'(rem);
      o.bz = 1'b1;
      o.pz = pz;
      if (rem > r + s) begin
         o.ph = 3'd2;
         o.pl = 6'(rem - r - s);
      end else if (rem > s) begin
         o.ph = 3'd3;
         o.pl = 6'(rem - s);
      end else begin
         o.ph = 3'd4;
         o.pl = 6'(rem);
      end
      return o;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      #2 rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({phase, charge_req, price, phase_left, total_left, busy, paused, done, err} !== '0) begin
         n_bad++;
         $display("FAIL reset_state: got phase=%0d req=%b price=%0d pl=%0d tl=%0d busy=%b paused=%b done=%b err=%b, expected all zero",
                  phase, charge_req, price, phase_left, total_left, busy, paused, done, err);
      end
      rst = 1'b1;
      @(negedge clk);
   endtask

   // abort_kind: 0 run to completion, 1 drop on at abort_at, 2 assert reset at abort_at.
   task automatic test_program(input string name, input logic [1:0] m, input int w, input int r,
                               input int s, input int pause_at, input int abort_at, input int abort_kind);
      obs_t got;
      obs_t exp;
      int   eff;
      int   dones;
      int   last;
      bit   pz;

      @(negedge clk);
      mode  = m;
      start = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (phase !== 3'd1 || charge_req !== 1'b1 || price !== price_of(m) || err !== 1'b0) begin
         n_bad++;
         $display("FAIL %s_charge: got phase=%0d req=%b price=%0d err=%b, expected phase=1 req=1 price=%0d err=0",
                  name, phase, charge_req, price, err, price_of(m));
      end
      mode = ~m;
      @(negedge clk);
      charge_ack = 1'b1;

      last = HZ * (w + r + s) + 1 + ((pause_at >= 0) ? 10 : 0);
      for (int t = 0; t <= last; t++) begin
         if (pause_at >= 0 && t > pause_at && t <= pause_at + 10) begin
            eff = pause_at;
            pz  = 1'b1;
         end else if (pause_at >= 0 && t > pause_at + 10) begin
            eff = t - 10;
            pz  = 1'b0;
         end else begin
            eff = t;
            pz  = 1'b0;
         end
         sb_q.push_back(model(w, r, s, eff, pz));
      end

      dones = 0;
      for (int t = 0; sb_q.size() > 0; t++) begin
         @(negedge clk);
         if (t == 0) charge_ack = 1'b0;
         exp = sb_q.pop_front();
         got = {phase, phase_left, total_left, busy, paused, done};
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL %s_trace t=%0d: got ph=%0d pl=%0d tl=%0d busy/paused/done=%b%b%b, expected ph=%0d pl=%0d tl=%0d busy/paused/done=%b%b%b",
                     name, t, got.ph, got.pl, got.tl, got.bz, got.pz, got.dn, exp.ph, exp.pl, exp.tl, exp.bz, exp.pz, exp.dn);
         end
         if (done === 1'b1) dones++;
         if (pause_at >= 0 && t == pause_at) pause = 1'b1;
         if (pause_at >= 0 && t == pause_at + 10) pause = 1'b0;
         if (t == 10) start = 1'b0;
         if (t == 11) start = 1'b1;
         if (t == abort_at) begin
            sb_q.delete();
            start = 1'b0;
            if (abort_kind == 1) begin
               on = 1'b0;
               @(negedge clk);
               n_cmp++;
               if ({phase, phase_left, total_left, busy, charge_req, done, err} !== '0) begin
                  n_bad++;
                  $display("FAIL %s_off: got phase=%0d pl=%0d tl=%0d busy=%b req=%b done=%b err=%b, expected all zero",
                           name, phase, phase_left, total_left, busy, charge_req, done, err);
               end
               on = 1'b1;
            end else begin
               rst = 1'b0;
               #1;
               n_cmp++;
               if ({phase, charge_req, price, phase_left, total_left, busy, paused, done, err} !== '0) begin
                  n_bad++;
                  $display("FAIL %s_rst: got phase=%0d req=%b price=%0d pl=%0d tl=%0d busy=%b paused=%b done=%b err=%b, expected all zero",
                           name, phase, charge_req, price, phase_left, total_left, busy, paused, done, err);
               end
               @(negedge clk);
               rst = 1'b1;
            end
         end
      end

      if (abort_at >= 0) begin
         for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done === 1'b1 || charge_req === 1'b1 || phase !== 3'd0) dones++;
         end
         n_cmp++;
         if (dones !== 0) begin
            n_bad++;
            $display("FAIL %s_quiet: got %0d cycles with done/charge_req/non-idle phase, expected 0", name, dones);
         end
      end else begin
         n_cmp++;
         if (dones !== 1) begin
            n_bad++;
            $display("FAIL %s_done_count: got %0d done pulses, expected 1", name, dones);
         end
         repeat (8) @(negedge clk);
         n_cmp++;
         if (phase !== 3'd0 || charge_req !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_no_restart: got phase=%0d req=%b with start held, expected phase=0 req=0",
                     name, phase, charge_req);
         end
         start = 1'b0;
      end
      mode = 2'b00;
      @(negedge clk);
   endtask

   task automatic test_nak();
      @(negedge clk);
      mode  = 2'b11;
      start = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (phase !== 3'd1 || charge_req !== 1'b1 || price !== 12'd12) begin
         n_bad++;
         $display("FAIL nak_charge: got phase=%0d req=%b price=%0d, expected phase=1 req=1 price=12", phase, charge_req, price);
      end
      repeat (5) @(negedge clk);
      n_cmp++;
      if (phase !== 3'd1 || charge_req !== 1'b1) begin
         n_bad++;
         $display("FAIL nak_hold: got phase=%0d req=%b, expected phase=1 req=1", phase, charge_req);
      end
      start      = 1'b0;
      charge_nak = 1'b1;
      @(negedge clk);
      charge_nak = 1'b0;
      n_cmp++;
      if (phase !== 3'd0 || err !== 1'b1 || charge_req !== 1'b0 || price !== 12'd0) begin
         n_bad++;
         $display("FAIL nak_reject: got phase=%0d err=%b req=%b price=%0d, expected phase=0 err=1 req=0 price=0",
                  phase, err, charge_req, price);
      end
      repeat (3) @(negedge clk);
      n_cmp++;
      if (err !== 1'b1) begin
         n_bad++;
         $display("FAIL nak_sticky: got err=%b, expected 1", err);
      end
      mode  = 2'b01;
      start = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (phase !== 3'd1 || err !== 1'b0 || price !== 12'd5) begin
         n_bad++;
         $display("FAIL nak_clear: got phase=%0d err=%b price=%0d, expected phase=1 err=0 price=5", phase, err, price);
      end
      start = 1'b0;
      on    = 1'b0;
      @(negedge clk);
      on = 1'b1;
      n_cmp++;
      if (phase !== 3'd0 || charge_req !== 1'b0 || err !== 1'b0) begin
         n_bad++;
         $display("FAIL charge_off: got phase=%0d req=%b err=%b, expected phase=0 req=0 err=0", phase, charge_req, err);
      end
      @(negedge clk);
   endtask

   task automatic test_ack_nak();
      @(negedge clk);
      mode  = 2'b10;
      start = 1'b1;
      @(negedge clk);
      start      = 1'b0;
      charge_ack = 1'b1;
      charge_nak = 1'b1;
      @(negedge clk);
      charge_ack = 1'b0;
      charge_nak = 1'b0;
      n_cmp++;
      if (phase !== 3'd0 || err !== 1'b1 || charge_req !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL ack_nak: got phase=%0d err=%b req=%b busy=%b, expected phase=0 err=1 req=0 busy=0",
                  phase, err, charge_req, busy);
      end
      @(negedge clk);
   endtask

   initial begin
      rst        = 1'b1;
      on         = 1'b1;
      start      = 1'b0;
      pause      = 1'b0;
      mode       = 2'b00;
      charge_ack = 1'b0;
      charge_nak = 1'b0;

      test_reset();
      test_program("small", 2'b01, 10, 6, 4, -1, -1, 0);
      test_nak();
      test_ack_nak();
      test_program("dry", 2'b00, 0, 0, 6, -1, -1, 0);
      test_program("medium_pause", 2'b10, 15, 8, 6, 20, -1, 0);
      test_program("large", 2'b11, 20, 10, 8, -1, -1, 0);
      test_program("abort_on", 2'b01, 10, 6, 4, -1, 50, 1);
      test_program("abort_rst", 2'b01, 10, 6, 4, -1, 70, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
